// File: rtl/vga_pkg.sv
// Shared VGA timing constants and types for the raster generator.
// Defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;

  typedef enum logic [0:0] {
    WAIT_LOCK,
    RUN
  } sync_state_t;

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Video timing bundle from the sync generator to the pixel pipeline / VGA connector.
interface vga_sync_gen_if #(
  parameter int unsigned XW = 10,
  parameter int unsigned YW = 10
);

  logic          hsync;
  logic          vsync;
  logic          active;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          line_start;
  logic          frame_start;

  modport master (
    output hsync, vsync, active, x, y, line_start, frame_start
  );

  modport slave (
    input hsync, vsync, active, x, y, line_start, frame_start
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: count with enable, wrap pulse and clear, plus interval decode.
// Interval order is active, front porch, sync, back porch.
module vga_axis_counter #(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48,
  parameter int unsigned W      = $clog2(ACTIVE + FP + SYNC + BP)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         in_active,
  output logic         in_sync
);

  localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;

  logic [W-1:0] count_d;
  logic [31:0]  cnt32;

  // Widen once so interval bounds never truncate when TOTAL is a power of two.
  assign cnt32 = 32'(count);

  assign wrap      = en && (cnt32 == TOTAL - 1);
  assign in_active = cnt32 < ACTIVE;
  assign in_sync   = (cnt32 >= ACTIVE + FP) && (cnt32 < ACTIVE + FP + SYNC);

  always_comb begin
    count_d = count;
    if (clr) begin
      count_d = '0;
    end else if (wrap) begin
      count_d = '0;
    end else if (en) begin
      count_d = count + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_d;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: lock-qualified h/v counters with registered sync,
// active-video, coordinate and line/frame strobe outputs.
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::V_BP,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic           clk_in,
  input  logic           resetn,
  input  logic           locked,
  input  logic           pix_en,
  vga_sync_gen_if.master vid
);

  import vga_pkg::*;

  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned XW      = $clog2(H_TOTAL);
  localparam int unsigned YW      = $clog2(V_TOTAL);

  sync_state_t   state;
  logic          advance;
  logic          h_wrap;
  logic          h_act;
  logic          h_sync;
  logic          v_act;
  logic          v_sync;
  logic [XW-1:0] h_count;
  logic [YW-1:0] v_count;

  assign advance = (state == RUN) && locked && pix_en;

  // Counters clear on the same edge that drops lock, wherever in the frame that is.
  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .W      (XW)
  ) u_h_cnt (
    .clk       (clk_in),
    .rst_n     (resetn),
    .clr       (!locked),
    .en        (advance),
    .count     (h_count),
    .wrap      (h_wrap),
    .in_active (h_act),
    .in_sync   (h_sync)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .W      (YW)
  ) u_v_cnt (
    .clk       (clk_in),
    .rst_n     (resetn),
    .clr       (!locked),
    .en        (h_wrap),
    .count     (v_count),
    .wrap      (),
    .in_active (v_act),
    .in_sync   (v_sync)
  );

  always_ff @(posedge clk_in or negedge resetn) begin
    if (!resetn) begin
      state           <= WAIT_LOCK;
      vid.hsync       <= ~SYNC_POL;
      vid.vsync       <= ~SYNC_POL;
      vid.active      <= 1'b0;
      vid.x           <= '0;
      vid.y           <= '0;
      vid.line_start  <= 1'b0;
      vid.frame_start <= 1'b0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          if (locked) begin
            state <= RUN;
          end
          vid.hsync       <= ~SYNC_POL;
          vid.vsync       <= ~SYNC_POL;
          vid.active      <= 1'b0;
          vid.x           <= '0;
          vid.y           <= '0;
          vid.line_start  <= 1'b0;
          vid.frame_start <= 1'b0;
        end
        RUN: begin
          if (!locked) begin
            state           <= WAIT_LOCK;
            vid.hsync       <= ~SYNC_POL;
            vid.vsync       <= ~SYNC_POL;
            vid.active      <= 1'b0;
            vid.x           <= '0;
            vid.y           <= '0;
            vid.line_start  <= 1'b0;
            vid.frame_start <= 1'b0;
          end else if (pix_en) begin
            // Decode the position held before this edge's increment.
            vid.hsync       <= h_sync ? SYNC_POL : ~SYNC_POL;
            vid.vsync       <= v_sync ? SYNC_POL : ~SYNC_POL;
            vid.active      <= h_act && v_act;
            vid.x           <= (h_act && v_act) ? h_count : '0;
            vid.y           <= (h_act && v_act) ? v_count : '0;
            vid.line_start  <= (h_count == '0);
            vid.frame_start <= (h_count == '0) && (v_count == '0);
          end else begin
            vid.line_start  <= 1'b0;
            vid.frame_start <= 1'b0;
          end
        end
        default: state <= WAIT_LOCK;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: reduced-timing (both polarities) and default-timing instances
// checked against a frame-position reference model plus period/offset measurements.
module tb_vga_sync_gen;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       act;
    logic [9:0] x;
    logic [9:0] y;
    logic       ls;
    logic       fs;
  } vid_t;

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  logic locked = 1'b0;
  logic pix_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vga_sync_gen_if #(.XW(3),  .YW(3))  if_r ();
  vga_sync_gen_if #(.XW(3),  .YW(3))  if_p ();
  vga_sync_gen_if #(.XW(10), .YW(10)) if_d ();

  vga_sync_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
  ) dut_r (
    .clk_in (clk), .resetn (resetn), .locked (locked), .pix_en (pix_en), .vid (if_r)
  );

  vga_sync_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
  ) dut_p (
    .clk_in (clk), .resetn (resetn), .locked (locked), .pix_en (pix_en), .vid (if_p)
  );

  vga_sync_gen dut_d (
    .clk_in (clk), .resetn (resetn), .locked (locked), .pix_en (pix_en), .vid (if_d)
  );

  vid_t o_r, o_p, o_d;
  assign o_r = {if_r.hsync, if_r.vsync, if_r.active, 10'(if_r.x), 10'(if_r.y),
                if_r.line_start, if_r.frame_start};
  assign o_p = {if_p.hsync, if_p.vsync, if_p.active, 10'(if_p.x), 10'(if_p.y),
                if_p.line_start, if_p.frame_start};
  assign o_d = {if_d.hsync, if_d.vsync, if_d.active, 10'(if_d.x), 10'(if_d.y),
                if_d.line_start, if_d.frame_start};

  function automatic vid_t idle(input bit pol);
    vid_t e;
    e    = '0;
    e.hs = ~pol;
    e.vs = ~pol;
    return e;
  endfunction

  // Expected outputs for a linear pixel index within the frame.
  function automatic vid_t decode(input int pos, input int ha, input int hf, input int hsw,
                                  input int hb, input int va, input int vf, input int vsw,
                                  input bit pol);
    vid_t e;
    int   ht, h, v;
    ht    = ha + hf + hsw + hb;
    h     = pos % ht;
    v     = pos / ht;
    e     = '0;
    e.hs  = (h >= ha + hf && h < ha + hf + hsw) ? pol : ~pol;
    e.vs  = (v >= va + vf && v < va + vf + vsw) ? pol : ~pol;
    e.act = (h < ha) && (v < va);
    e.x   = e.act ? 10'(h) : 10'd0;
    e.y   = e.act ? 10'(v) : 10'd0;
    e.ls  = (h == 0);
    e.fs  = (pos == 0);
    return e;
  endfunction

  bit   m_run;
  int   pos_r, pos_d;
  vid_t exp_r, exp_p, exp_d;

  always @(posedge clk or negedge resetn) begin
    if (!resetn || !locked) begin
      m_run <= 1'b0;
      pos_r <= 0;
      pos_d <= 0;
      exp_r <= idle(1'b0);
      exp_p <= idle(1'b1);
      exp_d <= idle(1'b0);
    end else if (!m_run) begin
      m_run <= 1'b1;
    end else if (pix_en) begin
      exp_r <= decode(pos_r, 4, 1, 2, 1, 3, 1, 1, 1'b0);
      exp_p <= decode(pos_r, 4, 1, 2, 1, 3, 1, 1, 1'b1);
      exp_d <= decode(pos_d, 640, 16, 96, 48, 480, 10, 2, 1'b0);
      pos_r <= (pos_r + 1) % 48;
      pos_d <= (pos_d + 1) % 420000;
    end else begin
      exp_r.ls <= 1'b0;
      exp_r.fs <= 1'b0;
      exp_p.ls <= 1'b0;
      exp_p.fs <= 1'b0;
      exp_d.ls <= 1'b0;
      exp_d.fs <= 1'b0;
    end
  end

  task automatic test_reset();
    locked = 1'b0;
    pix_en = 1'b1;
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (o_r !== idle(1'b0)) begin n_bad++; $display("FAIL reset_r: got %h want %h", o_r, idle(1'b0)); end
    n_cmp++; if (o_p !== idle(1'b1)) begin n_bad++; $display("FAIL reset_p: got %h want %h", o_p, idle(1'b1)); end
    n_cmp++; if (o_d !== idle(1'b0)) begin n_bad++; $display("FAIL reset_d: got %h want %h", o_d, idle(1'b0)); end
    resetn = 1'b1;
  endtask

  task automatic test_idle_unlocked();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++; if (o_r !== idle(1'b0)) begin n_bad++; $display("FAIL unlocked_r: got %h want %h", o_r, idle(1'b0)); end
      n_cmp++; if (o_p !== idle(1'b1)) begin n_bad++; $display("FAIL unlocked_p: got %h want %h", o_p, idle(1'b1)); end
    end
  endtask

  task automatic test_first_decode();
    vid_t want0, want1;
    want0 = idle(1'b0); want0.act = 1'b1; want0.ls = 1'b1; want0.fs = 1'b1;
    want1 = idle(1'b1); want1.act = 1'b1; want1.ls = 1'b1; want1.fs = 1'b1;
    @(negedge clk);
    locked = 1'b1;
    @(negedge clk);
    n_cmp++; if (o_r !== idle(1'b0)) begin n_bad++; $display("FAIL lock_edge_r: got %h want %h", o_r, idle(1'b0)); end
    @(negedge clk);
    n_cmp++; if (o_r !== want0) begin n_bad++; $display("FAIL first_px_r: got %h want %h", o_r, want0); end
    n_cmp++; if (o_p !== want1) begin n_bad++; $display("FAIL first_px_p: got %h want %h", o_p, want1); end
    n_cmp++; if (o_d !== want0) begin n_bad++; $display("FAIL first_px_d: got %h want %h", o_d, want0); end
  endtask

  task automatic test_reduced_frame();
    int last = -1;
    int per  = -1;
    pix_en = 1'b1;
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      n_cmp++; if (o_r !== exp_r) begin n_bad++; $display("FAIL frame_r: got %h want %h", o_r, exp_r); end
      n_cmp++; if (o_p !== exp_p) begin n_bad++; $display("FAIL frame_p: got %h want %h", o_p, exp_p); end
      n_cmp++; if (o_d !== exp_d) begin n_bad++; $display("FAIL frame_d: got %h want %h", o_d, exp_d); end
      if (o_r.fs) begin
        if (last >= 0) per = i - last;
        last = i;
      end
    end
    n_cmp++; if (per != 48) begin n_bad++; $display("FAIL frame_period: got %0d want 48", per); end
  endtask

  // Default-timing line period, hsync offset/width and strobe width at pix_en = 1-in-div.
  task automatic test_line_timing(input int div);
    int last = -1, per = -1, hs_off = -1, hs_w = -1, low = 0, dbl = 0;
    bit prev_hs = 1'b1;
    bit prev_ls = 1'b0;
    for (int i = 0; i < div * 2500; i++) begin
      pix_en = (i % div == 0);
      @(negedge clk);
      n_cmp++; if (o_r !== exp_r) begin n_bad++; $display("FAIL line_r: got %h want %h", o_r, exp_r); end
      n_cmp++; if (o_p !== exp_p) begin n_bad++; $display("FAIL line_p: got %h want %h", o_p, exp_p); end
      n_cmp++; if (o_d !== exp_d) begin n_bad++; $display("FAIL line_d: got %h want %h", o_d, exp_d); end
      if (o_d.ls && prev_ls) dbl++;
      if (o_d.ls) begin
        if (last >= 0) per = i - last;
        last = i;
      end
      if (!o_d.hs && prev_hs && last >= 0) begin
        hs_off = i - last;
        low    = 0;
      end
      if (!o_d.hs) low++;
      if (o_d.hs && !prev_hs && hs_off >= 0) hs_w = low;
      prev_hs = o_d.hs;
      prev_ls = o_d.ls;
    end
    n_cmp++; if (per != 800 * div) begin n_bad++; $display("FAIL line_period: got %0d want %0d", per, 800 * div); end
    n_cmp++; if (hs_off != 656 * div) begin n_bad++; $display("FAIL hsync_offset: got %0d want %0d", hs_off, 656 * div); end
    n_cmp++; if (hs_w != 96 * div) begin n_bad++; $display("FAIL hsync_width: got %0d want %0d", hs_w, 96 * div); end
    n_cmp++; if (dbl != 0) begin n_bad++; $display("FAIL strobe_width: got %0d wide strobes want 0", dbl); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      pix_en = ($urandom_range(0, 3) != 0);
      locked = ($urandom_range(0, 199) != 0);
      @(negedge clk);
      n_cmp++; if (o_r !== exp_r) begin n_bad++; $display("FAIL rand_r: got %h want %h", o_r, exp_r); end
      n_cmp++; if (o_p !== exp_p) begin n_bad++; $display("FAIL rand_p: got %h want %h", o_p, exp_p); end
      n_cmp++; if (o_d !== exp_d) begin n_bad++; $display("FAIL rand_d: got %h want %h", o_d, exp_d); end
    end
  endtask

  task automatic test_lock_drop();
    bit   found = 1'b0;
    vid_t want0;
    want0 = idle(1'b0); want0.act = 1'b1; want0.ls = 1'b1; want0.fs = 1'b1;
    locked = 1'b1;
    pix_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (m_run && pos_r == 29) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL lock_drop_wait: got timeout want h=5,v=3 reached");
    end else begin
      locked = 1'b0;
      @(negedge clk);
      n_cmp++; if (o_r !== idle(1'b0)) begin n_bad++; $display("FAIL drop_r: got %h want %h", o_r, idle(1'b0)); end
      n_cmp++; if (o_p !== idle(1'b1)) begin n_bad++; $display("FAIL drop_p: got %h want %h", o_p, idle(1'b1)); end
      locked = 1'b1;
      @(negedge clk);
      n_cmp++; if (o_r !== idle(1'b0)) begin n_bad++; $display("FAIL relock_edge_r: got %h want %h", o_r, idle(1'b0)); end
      @(negedge clk);
      n_cmp++; if (o_r !== want0) begin n_bad++; $display("FAIL relock_px_r: got %h want %h", o_r, want0); end
    end
  endtask

  task automatic test_async_reset();
    locked = 1'b1;
    pix_en = 1'b1;
    repeat (20) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    n_cmp++; if (o_r !== idle(1'b0)) begin n_bad++; $display("FAIL async_rst_r: got %h want %h", o_r, idle(1'b0)); end
    n_cmp++; if (o_p !== idle(1'b1)) begin n_bad++; $display("FAIL async_rst_p: got %h want %h", o_p, idle(1'b1)); end
    n_cmp++; if (o_d !== idle(1'b0)) begin n_bad++; $display("FAIL async_rst_d: got %h want %h", o_d, idle(1'b0)); end
    locked = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_cmp++; if (o_r !== idle(1'b0)) begin n_bad++; $display("FAIL held_idle_r: got %h want %h", o_r, idle(1'b0)); end
      n_cmp++; if (o_d !== idle(1'b0)) begin n_bad++; $display("FAIL held_idle_d: got %h want %h", o_d, idle(1'b0)); end
    end
  endtask

  initial begin
    test_reset();
    test_idle_unlocked();
    test_first_decode();
    test_reduced_frame();
    test_line_timing(1);
    test_line_timing(4);
    test_random();
    test_lock_drop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
